// File: rtl/wb_decoder_2.sv
// wb_decoder_2 -- Wishbone one-master to two-slave address decoder.
//
// Sits downstream of an arbiter and fans a single master out to two slave
// regions. Each transfer is decoded once in IDLE and the chosen slave is held
// in a 1-bit select register for the rest of the transfer. Unmapped addresses
// and slaves that never terminate both end in a one-cycle ERR state that
// returns a bus error to the master.
//
// Ports
//   clk, rst                  clock; synchronous reset, active-low (0 = reset)
//   wbm_adr_i/dat_i/we_i/sel_i master request signals
//   wbm_stb_i, wbm_cyc_i      master strobe / cycle
//   wbm_dat_o                 read data of the selected slave, 0 otherwise
//   wbm_ack_o/err_o/rty_o     termination back to the master
//   wbsN_adr_o/dat_o/we_o/sel_o  request broadcast to both slaves (N = 0,1)
//   wbsN_stb_o/cyc_o          strobe/cycle, only to the selected slave
//   wbsN_dat_i/ack_i/err_i/rty_i slave responses
//   dec_err_o                 one-cycle pulse, unmapped address
//   timeout_o                 one-cycle pulse, watchdog expiry
module wb_decoder_2 #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter logic [ADDR_WIDTH-1:0] WBS0_ADDR = '0,
  parameter logic [ADDR_WIDTH-1:0] WBS0_MASK = ADDR_WIDTH'(32'hF000_0000),
  parameter logic [ADDR_WIDTH-1:0] WBS1_ADDR = ADDR_WIDTH'(32'h1000_0000),
  parameter logic [ADDR_WIDTH-1:0] WBS1_MASK = ADDR_WIDTH'(32'hF000_0000),
  parameter int TIMEOUT      = 256
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic [ADDR_WIDTH-1:0]   wbm_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
  output logic [DATA_WIDTH-1:0]   wbm_dat_o,
  input  logic                    wbm_we_i,
  input  logic [SELECT_WIDTH-1:0] wbm_sel_i,
  input  logic                    wbm_stb_i,
  input  logic                    wbm_cyc_i,
  output logic                    wbm_ack_o,
  output logic                    wbm_err_o,
  output logic                    wbm_rty_o,

  output logic [ADDR_WIDTH-1:0]   wbs0_adr_o,
  output logic [DATA_WIDTH-1:0]   wbs0_dat_o,
  output logic                    wbs0_we_o,
  output logic [SELECT_WIDTH-1:0] wbs0_sel_o,
  output logic                    wbs0_stb_o,
  output logic                    wbs0_cyc_o,
  input  logic [DATA_WIDTH-1:0]   wbs0_dat_i,
  input  logic                    wbs0_ack_i,
  input  logic                    wbs0_err_i,
  input  logic                    wbs0_rty_i,

  output logic [ADDR_WIDTH-1:0]   wbs1_adr_o,
  output logic [DATA_WIDTH-1:0]   wbs1_dat_o,
  output logic                    wbs1_we_o,
  output logic [SELECT_WIDTH-1:0] wbs1_sel_o,
  output logic                    wbs1_stb_o,
  output logic                    wbs1_cyc_o,
  input  logic [DATA_WIDTH-1:0]   wbs1_dat_i,
  input  logic                    wbs1_ack_i,
  input  logic                    wbs1_err_i,
  input  logic                    wbs1_rty_i,

  output logic                    dec_err_o,
  output logic                    timeout_o
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    ERR    = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             sel, sel_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  // Remembers whether the pending ERR cycle came from a decode miss
  // (dec_err_o) or from the watchdog (timeout_o already pulsed).
  logic             dec_flag, dec_flag_nxt;

  logic                  req;
  logic                  run;
  logic                  active;
  logic                  in_err;
  logic                  s_ack, s_err, s_rty;
  logic                  term;
  logic                  expired;
  logic [DATA_WIDTH-1:0] s_dat;

  function automatic logic addr_hit(input logic [ADDR_WIDTH-1:0] adr,
                                    input logic [ADDR_WIDTH-1:0] base,
                                    input logic [ADDR_WIDTH-1:0] mask);
    return (adr & mask) == base;
  endfunction

  assign req = wbm_cyc_i & wbm_stb_i;

  // Holding rst low forces every control output low straight away, so a
  // transfer in flight is cut off in the same cycle reset is asserted.
  assign run    = rst;
  assign active = run & (state == ACTIVE);
  assign in_err = run & (state == ERR);

  assign s_ack = sel ? wbs1_ack_i : wbs0_ack_i;
  assign s_err = sel ? wbs1_err_i : wbs0_err_i;
  assign s_rty = sel ? wbs1_rty_i : wbs0_rty_i;
  assign s_dat = sel ? wbs1_dat_i : wbs0_dat_i;
  assign term  = s_ack | s_err | s_rty;

  // Expiry only counts while the master still holds the cycle; a slave
  // termination in the same cycle takes precedence.
  assign expired = active & wbm_cyc_i & ~term & (cnt == CNT_LAST);

  // Request is broadcast; only strobe/cycle are steered.
  assign wbs0_adr_o = wbm_adr_i;
  assign wbs0_dat_o = wbm_dat_i;
  assign wbs0_we_o  = wbm_we_i;
  assign wbs0_sel_o = wbm_sel_i;
  assign wbs1_adr_o = wbm_adr_i;
  assign wbs1_dat_o = wbm_dat_i;
  assign wbs1_we_o  = wbm_we_i;
  assign wbs1_sel_o = wbm_sel_i;

  assign wbs0_cyc_o = active & ~sel & wbm_cyc_i;
  assign wbs0_stb_o = active & ~sel & wbm_stb_i;
  assign wbs1_cyc_o = active &  sel & wbm_cyc_i;
  assign wbs1_stb_o = active &  sel & wbm_stb_i;

  assign wbm_ack_o = active & s_ack;
  assign wbm_rty_o = active & s_rty;
  assign wbm_err_o = (active & s_err) | (in_err & wbm_cyc_i);
  assign wbm_dat_o = active ? s_dat : '0;

  assign dec_err_o = in_err & dec_flag;
  assign timeout_o = expired;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      sel      <= 1'b0;
      cnt      <= '0;
      dec_flag <= 1'b0;
    end else begin
      state    <= state_nxt;
      sel      <= sel_nxt;
      cnt      <= cnt_nxt;
      dec_flag <= dec_flag_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt    = state;
    sel_nxt      = sel;
    cnt_nxt      = cnt;
    dec_flag_nxt = dec_flag;

    unique case (state)
      IDLE: begin
        cnt_nxt      = '0;
        dec_flag_nxt = 1'b0;
        if (req) begin
          // Slave 0 is checked first so overlapping regions resolve to it.
          if (addr_hit(wbm_adr_i, WBS0_ADDR, WBS0_MASK)) begin
            state_nxt = ACTIVE;
            sel_nxt   = 1'b0;
          end else if (addr_hit(wbm_adr_i, WBS1_ADDR, WBS1_MASK)) begin
            state_nxt = ACTIVE;
            sel_nxt   = 1'b1;
          end else begin
            state_nxt    = ERR;
            dec_flag_nxt = 1'b1;
          end
        end
      end

      ACTIVE: begin
        cnt_nxt = cnt + 1'b1;
        if (!wbm_cyc_i || term) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt    = ERR;
          dec_flag_nxt = 1'b0;
        end
      end

      ERR: begin
        state_nxt    = IDLE;
        dec_flag_nxt = 1'b0;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
